// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: 16-bit word and the 2-bit memory write mask.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  localparam lc3b_mem_wmask WMASK_NONE = 2'b00;
  localparam lc3b_mem_wmask WMASK_LO   = 2'b01;
  localparam lc3b_mem_wmask WMASK_HI   = 2'b10;
  localparam lc3b_mem_wmask WMASK_WORD = 2'b11;

endpackage

// File: rtl/mem_byte_lane.sv
// Combinational byte-lane steering between the pipeline word view and the
// 16-bit memory bus: replicates store bytes, selects lanes, extracts load bytes.
module mem_byte_lane
  import lc3b_types::*;
(
  input  logic        addr_lsb,
  input  logic        byte_acc,
  input  logic [15:0] wdata_in,
  input  logic [15:0] mem_rdata,
  output logic [15:0] mem_wdata,
  output logic [1:0]  byte_en,
  output logic [15:0] rdata_out
);

  lc3b_word      wdata_w;
  lc3b_word      rdata_w;
  lc3b_mem_wmask be_w;

  always_comb begin
    wdata_w = wdata_in;
    rdata_w = mem_rdata;
    be_w    = WMASK_WORD;
    if (byte_acc) begin
      // Store byte goes on both lanes; the enable picks the one memory keeps.
      wdata_w = {wdata_in[7:0], wdata_in[7:0]};
      be_w    = addr_lsb ? WMASK_HI : WMASK_LO;
      rdata_w = {8'h00, (addr_lsb ? mem_rdata[15:8] : mem_rdata[7:0])};
    end
  end

  assign mem_wdata = wdata_w;
  assign byte_en   = be_w;
  assign rdata_out = rdata_w;

endmodule

// File: rtl/mem_access_unit.sv
// Pipeline-to-memory access sequencer (IDLE -> ACCESS -> DONE) with byte/word
// steering. Optional ACCESS timeout abort enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit
  import lc3b_types::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_read,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic [15:0] req_rdata,
  output logic        req_stall,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_rdata,
  input  logic        mem_resp,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t        state_q, state_d;
  lc3b_word      addr_q, addr_d;
  lc3b_word      wdata_q, wdata_d;
  lc3b_word      rdata_q, rdata_d;
  logic          byte_q, byte_d;
  logic          write_q, write_d;
  lc3b_word      lane_wdata, lane_rdata;
  lc3b_mem_wmask lane_be;
  logic          timeout_hit;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_access_unit: TIMEOUT_CYCLES must be at least 1");
  end

  mem_byte_lane u_lane (
    .addr_lsb  (addr_q[0]),
    .byte_acc  (byte_q),
    .wdata_in  (wdata_q),
    .mem_rdata (mem_rdata),
    .mem_wdata (lane_wdata),
    .byte_en   (lane_be),
    .rdata_out (lane_rdata)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // err_q is set on the ACCESS->DONE timeout edge, so it is high only in DONE.
  always_comb begin
    cnt_d = '0;
    err_d = 1'b0;
    if (state_q == S_ACCESS && !mem_resp) begin
      if (timeout_hit) begin
        cnt_d = cnt_q;
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    byte_d          = byte_q;
    write_d         = write_q;
    rdata_d         = rdata_q;
    req_stall       = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = WMASK_NONE;
    unique case (state_q)
      S_IDLE: begin
        // Stall is combinational so the pipeline holds in the request cycle.
        if (rst_n && (req_read || req_write)) begin
          req_stall = 1'b1;
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          byte_d    = req_byte;
          write_d   = req_write;
          state_d   = S_ACCESS;
        end
      end
      S_ACCESS: begin
        req_stall       = 1'b1;
        mem_read        = ~write_q;
        mem_write       = write_q;
        mem_byte_enable = lane_be;
        if (mem_resp) begin
          if (!write_q) rdata_d = lane_rdata;
          state_d = S_DONE;
        end else if (timeout_hit) begin
          rdata_d = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // Request capture registers carry no reset; they are only read in ACCESS.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    byte_q  <= byte_d;
    write_q <= write_d;
  end

  assign mem_address = {addr_q[15:1], 1'b0};
  assign mem_wdata   = lane_wdata;
  assign req_rdata   = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// transactions compared against a behavioural model of the access rules.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_read = 1'b0, req_write = 1'b0, req_byte = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
  logic        mem_resp = 1'b0;
  logic [15:0] req_rdata, mem_address, mem_wdata;
  logic        req_stall, mem_read, mem_write, err;
  logic [1:0]  mem_byte_enable;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] rdata_hold = '0;

  // Observations of one transaction, filled by run_txn.
  int          o_stall, o_acc;
  logic        o_rd, o_wr, o_err, o_done_strobe, o_hung, o_unstable;
  logic [15:0] o_addr, o_wdata, o_rdata;
  logic [1:0]  o_be;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_read        (req_read),
    .req_write       (req_write),
    .req_byte        (req_byte),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_rdata       (req_rdata),
    .req_stall       (req_stall),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .err             (err)
  );

  // Expected behaviour derived directly from the addressing/lane rules.
  function automatic logic [15:0] exp_addr(input logic [15:0] a);
    return a & 16'hFFFE;
  endfunction
  function automatic logic [1:0] exp_be(input logic byt, input logic [15:0] a);
    if (!byt) return 2'b11;
    return a[0] ? 2'b10 : 2'b01;
  endfunction
  function automatic logic [15:0] exp_wdata(input logic byt, input logic [15:0] w);
    if (!byt) return w;
    return (w & 16'h00FF) * 16'h0101;
  endfunction
  function automatic logic [15:0] exp_rdata(input logic byt, input logic [15:0] a, input logic [15:0] r);
    if (!byt) return r;
    return a[0] ? (r >> 8) : (r & 16'h00FF);
  endfunction

  // Drives one request and observes it until DONE; resp_at < 0 means no response.
  task automatic run_txn(input logic rd, input logic wr, input logic byt,
                         input logic [15:0] a, input logic [15:0] w,
                         input logic [15:0] r, input int resp_at);
    o_stall = 0; o_acc = 0; o_rd = 0; o_wr = 0; o_err = 0; o_done_strobe = 0;
    o_hung = 0; o_unstable = 0; o_addr = '0; o_wdata = '0; o_rdata = '0; o_be = '0;
    @(negedge clk);
    req_read = rd; req_write = wr; req_byte = byt; req_addr = a; req_wdata = w;
    #1 if (req_stall) o_stall++;
    @(negedge clk);
    req_read = 1'b0; req_write = 1'b0;
    req_byte = 1'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
    for (int i = 0; i < 40; i++) begin
      mem_resp  = (i == resp_at);
      mem_rdata = (i == resp_at) ? r : 16'($urandom);
      #1;
      if (!req_stall) begin
        o_rdata = req_rdata; o_err = err; o_done_strobe = mem_read | mem_write;
        break;
      end
      o_stall++;
      if (mem_read || mem_write) begin
        if (o_acc > 0 && (mem_address !== o_addr || mem_wdata !== o_wdata ||
                          mem_byte_enable !== o_be || mem_read !== o_rd))
          o_unstable = 1'b1;
        o_acc++; o_rd = mem_read; o_wr = mem_write;
        o_addr = mem_address; o_wdata = mem_wdata; o_be = mem_byte_enable;
      end
      if (i == 39) o_hung = 1'b1;
      @(negedge clk);
    end
    mem_resp = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_read = 1'b1;
    #2;
    n_tests++; if (req_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", req_stall); end
    n_tests++; if ({mem_read, mem_write} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes got %b want 00", {mem_read, mem_write}); end
    n_tests++; if (mem_byte_enable !== 2'b00) begin n_fail++; $display("FAIL reset_be got %b want 00", mem_byte_enable); end
    n_tests++; if (req_rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata got %h want 0000", req_rdata); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    @(negedge clk); @(negedge clk);
    req_read = 1'b0; rst_n = 1'b1;
    rdata_hold = '0;
  endtask

  task automatic test_word_load();
    run_txn(1'b1, 1'b0, 1'b0, 16'h1002, 16'h0000, 16'hBEEF, 0);
    rdata_hold = 16'hBEEF;
    n_tests++; if (o_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL word_load_rdata got %h want beef", o_rdata); end
    n_tests++; if (o_stall != 2) begin n_fail++; $display("FAIL word_load_stall got %0d want 2", o_stall); end
    n_tests++; if (o_addr !== 16'h1002 || o_be !== 2'b11 || o_rd !== 1'b1) begin
      n_fail++; $display("FAIL word_load_bus got addr=%h be=%b rd=%b want 1002/11/1", o_addr, o_be, o_rd); end
  endtask

  task automatic test_byte_store();
    run_txn(1'b0, 1'b1, 1'b1, 16'h2001, 16'h12AB, 16'h0000, 1);
    n_tests++; if (o_addr !== 16'h2000) begin n_fail++; $display("FAIL byte_store_addr got %h want 2000", o_addr); end
    n_tests++; if (o_wdata !== 16'hABAB) begin n_fail++; $display("FAIL byte_store_wdata got %h want abab", o_wdata); end
    n_tests++; if (o_be !== 2'b10 || o_wr !== 1'b1 || o_rd !== 1'b0) begin
      n_fail++; $display("FAIL byte_store_ctl got be=%b wr=%b rd=%b want 10/1/0", o_be, o_wr, o_rd); end
    n_tests++; if (o_stall != 3 || o_unstable) begin n_fail++; $display("FAIL byte_store_timing got stall=%0d unstable=%b want 3/0", o_stall, o_unstable); end
  endtask

  task automatic test_byte_load();
    run_txn(1'b1, 1'b0, 1'b1, 16'h3001, 16'h0000, 16'h7F80, 0);
    n_tests++; if (o_rdata !== 16'h007F) begin n_fail++; $display("FAIL byte_load_hi got %h want 007f", o_rdata); end
    n_tests++; if (o_be !== 2'b10 || o_addr !== 16'h3000) begin n_fail++; $display("FAIL byte_load_hi_bus got be=%b addr=%h want 10/3000", o_be, o_addr); end
    run_txn(1'b1, 1'b0, 1'b1, 16'h3000, 16'h0000, 16'h7F80, 2);
    rdata_hold = 16'h0080;
    n_tests++; if (o_rdata !== 16'h0080) begin n_fail++; $display("FAIL byte_load_lo got %h want 0080", o_rdata); end
    n_tests++; if (o_be !== 2'b01) begin n_fail++; $display("FAIL byte_load_lo_be got %b want 01", o_be); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      int          op    = $urandom_range(0, 2);
      logic        rd    = (op != 1);
      logic        wr    = (op != 0);
      logic        byt   = 1'($urandom);
      logic [15:0] a     = 16'($urandom);
      logic [15:0] w     = 16'($urandom);
      logic [15:0] r     = 16'($urandom);
      int          delay = $urandom_range(0, 2);
      run_txn(rd, wr, byt, a, w, r, delay);
      if (!wr) rdata_hold = exp_rdata(byt, a, r);
      n_tests++; if (o_stall != delay + 2 || o_acc != delay + 1 || o_hung) begin
        n_fail++; $display("FAIL rand_timing[%0d] got stall=%0d acc=%0d want %0d/%0d", t, o_stall, o_acc, delay + 2, delay + 1); end
      n_tests++; if (o_wr !== wr || o_rd !== !wr) begin
        n_fail++; $display("FAIL rand_dir[%0d] got rd=%b wr=%b want rd=%b wr=%b", t, o_rd, o_wr, !wr, wr); end
      n_tests++; if (o_addr !== exp_addr(a) || o_be !== exp_be(byt, a) || o_unstable) begin
        n_fail++; $display("FAIL rand_bus[%0d] got addr=%h be=%b unstable=%b want %h/%b/0", t, o_addr, o_be, o_unstable, exp_addr(a), exp_be(byt, a)); end
      if (wr) begin
        n_tests++; if (o_wdata !== exp_wdata(byt, w)) begin
          n_fail++; $display("FAIL rand_wdata[%0d] got %h want %h", t, o_wdata, exp_wdata(byt, w)); end
      end else begin
        n_tests++; if (o_rdata !== rdata_hold) begin
          n_fail++; $display("FAIL rand_rdata[%0d] got %h want %h", t, o_rdata, rdata_hold); end
      end
      n_tests++; if (o_err !== 1'b0 || o_done_strobe !== 1'b0) begin
        n_fail++; $display("FAIL rand_done[%0d] got err=%b strobe=%b want 0/0", t, o_err, o_done_strobe); end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] strobe_seen, stall_seen;
    int         accesses = 0;
    strobe_seen = '0; stall_seen = '0;
    @(negedge clk);
    req_read = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_addr = 16'h0456;
    mem_resp = 1'b1; mem_rdata = 16'h5A5A;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      strobe_seen[c] = mem_read | mem_write;
      stall_seen[c]  = req_stall;
      if (mem_read | mem_write) accesses++;
    end
    @(negedge clk);
    req_read = 1'b0; mem_resp = 1'b0;
    rdata_hold = 16'h5A5A;
    n_tests++; if (accesses != 2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", accesses); end
    n_tests++; if (strobe_seen !== 6'b010010) begin n_fail++; $display("FAIL b2b_strobe got %b want 010010", strobe_seen); end
    n_tests++; if (stall_seen !== 6'b011011) begin n_fail++; $display("FAIL b2b_stall got %b want 011011", stall_seen); end
    #1;
    n_tests++; if (req_rdata !== rdata_hold) begin n_fail++; $display("FAIL b2b_rdata got %h want %h", req_rdata, rdata_hold); end
  endtask

  task automatic test_timeout();
`ifdef MEM_TIMEOUT_EN
    run_txn(1'b1, 1'b0, 1'b0, 16'h5554, 16'h0000, 16'hFFFF, -1);
    n_tests++; if (o_acc != 4 || o_stall != 5 || o_hung) begin
      n_fail++; $display("FAIL timeout_len got acc=%0d stall=%0d want 4/5", o_acc, o_stall); end
    n_tests++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err got %b want 1", o_err); end
    n_tests++; if (o_rdata !== 16'h0000) begin n_fail++; $display("FAIL timeout_rdata got %h want 0000", o_rdata); end
    @(negedge clk); #1;
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL timeout_err_pulse got %b want 0", err); end
    rdata_hold = 16'h0000;
    run_txn(1'b1, 1'b0, 1'b0, 16'h5556, 16'h0000, 16'h1234, 1);
    rdata_hold = 16'h1234;
    n_tests++; if (o_err !== 1'b0 || o_rdata !== 16'h1234) begin
      n_fail++; $display("FAIL timeout_recover got err=%b rdata=%h want 0/1234", o_err, o_rdata); end
`else
    int held = 0;
    @(negedge clk);
    req_read = 1'b1; req_addr = 16'h5554;
    @(negedge clk);
    req_read = 1'b0; mem_resp = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1 if (mem_read && req_stall && !err) held++;
      @(negedge clk);
    end
    n_tests++; if (held != 20) begin n_fail++; $display("FAIL no_timeout_wait got %0d want 20 cycles held", held); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL no_timeout_err got %b want 0", err); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rdata_hold = 16'h0000;
`endif
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_write = 1'b1; req_addr = 16'h4444; req_wdata = 16'h9999; mem_resp = 1'b0;
    @(negedge clk);
    req_write = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_tests++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre got %b want 1", mem_write); end
    rst_n = 1'b0;
    #1;
    n_tests++; if ({mem_read, mem_write, req_stall} !== 3'b000) begin
      n_fail++; $display("FAIL rst_mid_now got rd/wr/stall=%b want 000", {mem_read, mem_write, req_stall}); end
    n_tests++; if (req_rdata !== 16'h0000 || err !== 1'b0 || mem_byte_enable !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid_regs got rdata=%h err=%b be=%b want 0000/0/00", req_rdata, err, mem_byte_enable); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_tests++; if ({mem_read, mem_write, req_stall} !== 3'b000) begin
        n_fail++; $display("FAIL rst_mid_idle[%0d] got rd/wr/stall=%b want 000", c, {mem_read, mem_write, req_stall}); end
    end
    rdata_hold = 16'h0000;
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_store();
    test_byte_load();
    test_random();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
